// File: rtl/alu_ctrl_fsm.sv
// Multicycle main-control FSM: sequences fetch/decode/execute for add, sub, and, addi, beq, j
// and drives the datapath enables plus the ALU-control mux inputs as pure Moore outputs.
module alu_ctrl_fsm #(
  parameter int unsigned FETCH_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [2:0] ALU_op,
  output logic [1:0] alu_ctrl_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_read,
  output logic       ir_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] exc_code,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH_RD  = 4'd1,
    S_FETCH_WT  = 4'd2,
    S_FETCH_IR  = 4'd3,
    S_DECODE    = 4'd4,
    S_R_EXEC    = 4'd5,
    S_R_WB      = 4'd6,
    S_ADDI_EXEC = 4'd7,
    S_ADDI_WB   = 4'd8,
    S_BEQ       = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(FETCH_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [1:0] exc_reg, exc_next;

  // The branch decision lives in the datapath (pc_write_cond & zero), not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RESET;
      cnt_reg   <= 3'd0;
      exc_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      exc_reg   <= exc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exc_next   = exc_reg;
    case (state_reg)
      S_RESET: state_next = S_FETCH_RD;
      S_FETCH_RD: begin
        if (WAIT_CNT == 3'd0) begin
          state_next = S_FETCH_IR;
        end else begin
          state_next = S_FETCH_WT;
          cnt_next   = 3'd1;
        end
      end
      S_FETCH_WT: begin
        if (cnt_reg == WAIT_CNT) begin
          state_next = S_FETCH_IR;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      S_FETCH_IR: state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE &&
            (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)) begin
          state_next = S_R_EXEC;
        end else if (opcode == OP_ADDI) begin
          state_next = S_ADDI_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_next = S_BEQ;
        end else if (opcode == OP_J) begin
          state_next = S_JUMP;
        end else begin
          state_next = S_HALT;
          exc_next   = 2'b01;
        end
      end
      S_R_EXEC: begin
        // A logical and cannot overflow, so the flag is only honoured for add/sub.
        if (overflow && funct != FN_AND) begin
          state_next = S_HALT;
          exc_next   = 2'b10;
        end else begin
          state_next = S_R_WB;
        end
      end
      S_ADDI_EXEC: begin
        if (overflow) begin
          state_next = S_HALT;
          exc_next   = 2'b10;
        end else begin
          state_next = S_ADDI_WB;
        end
      end
      S_R_WB, S_ADDI_WB, S_BEQ, S_JUMP: state_next = S_FETCH_RD;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    ALU_op        = 3'b000;
    alu_ctrl_sel  = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_read      = 1'b0;
    ir_write      = 1'b0;
    ab_write      = 1'b0;
    aluout_write  = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    case (state_reg)
      S_FETCH_RD: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ALU_op    = 3'b001;
      end
      S_FETCH_WT: mem_read = 1'b1;
      S_FETCH_IR: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        ALU_op    = 3'b001;
      end
      S_DECODE: begin
        ab_write     = 1'b1;
        aluout_write = 1'b1;
        alu_src_b    = 2'b11;
        ALU_op       = 3'b001;
      end
      S_R_EXEC: begin
        alu_src_a    = 1'b1;
        alu_ctrl_sel = 2'b01;
        aluout_write = 1'b1;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        ALU_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a     = 1'b1;
        ALU_op        = 3'b010;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign exc_code  = exc_reg;
  assign state_out = state_reg;

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle main-control FSM for the datapath. It sits directly upstream of the ALU-control mux and drives its `ALU_op` and `selector` inputs.
- Also drives PC, IR, A/B, ALUOut and register-file enables for the subset: add, sub, and (R-type), addi, beq, j.
- Illegal opcode/funct and arithmetic overflow halt the FSM with an exception code until reset.
- All outputs are Moore outputs: registered state, combinational decode of the state only.

Parameters:
- FETCH_WAIT, 1, memory read wait cycles between FETCH_RD and FETCH_IR. Legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- overflow  input  1  ALU overflow flag, combinational, same cycle as the operation
- ALU_op  output  3  000 load A, 001 add, 010 sub, 011 and; direct ALU operation for the mux
- alu_ctrl_sel  output  2  00 = use ALU_op, 01 = decode funct; 10/11 never driven
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write  output  1  unconditional PC write
- pc_write_cond  output  1  PC write if zero
- mem_read  output  1  instruction memory read
- ir_write  output  1  IR load
- ab_write  output  1  A/B register load
- aluout_write  output  1  ALUOut load
- reg_write  output  1  register file write
- reg_dst  output  1  0 = rt, 1 = rd
- exc_code  output  2  00 none, 01 illegal instruction, 10 overflow
- state_out  output  4  current state encoding, for debug

Behaviour:
- State encoding: RESET=0, FETCH_RD=1, FETCH_WAIT_ST=2, FETCH_IR=3, DECODE=4, R_EXEC=5, R_WB=6, ADDI_EXEC=7, ADDI_WB=8, BEQ=9, JUMP=10, HALT=11.
- Reset: while reset is high at a clock edge, next state = RESET and the wait counter clears to 0. In RESET every output is 0 (ALU_op=000, alu_ctrl_sel=00, exc_code=00). RESET -> FETCH_RD unconditionally.
- Reset overrides every state, including mid-instruction and HALT.
- Any output not listed for a state is 0.
- FETCH_RD: mem_read=1, alu_src_a=0, alu_src_b=01, ALU_op=001.
  - FETCH_WAIT=0 -> FETCH_IR.
  - Otherwise -> FETCH_WAIT_ST and the counter loads 1.
- FETCH_WAIT_ST: mem_read=1.
  - Counter == FETCH_WAIT -> FETCH_IR and the counter clears.
  - Otherwise the counter increments and the FSM stays.
- FETCH_IR: ir_write=1, pc_write=1, pc_source=00, alu_src_a=0, alu_src_b=01, ALU_op=001. The PC becomes PC+4. Next state is DECODE.
- DECODE: ab_write=1, aluout_write=1, alu_src_a=0, alu_src_b=11, ALU_op=001 (branch target). Next state by opcode:
  - 0x00 with funct in {0x20, 0x22, 0x24} -> R_EXEC
  - 0x08 -> ADDI_EXEC
  - 0x04 -> BEQ
  - 0x02 -> JUMP
  - anything else, including opcode 0x00 with another funct -> HALT with exc_code 01
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=01, ALU_op=000, aluout_write=1.
  - overflow=1 with funct 0x20 or 0x22 -> HALT with exc_code 10.
  - Otherwise -> R_WB. Overflow is ignored for "and".
- R_WB: reg_write=1, reg_dst=1. Next state is FETCH_RD.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ALU_op=001, aluout_write=1.
  - overflow=1 -> HALT with exc_code 10.
  - Otherwise -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Next state is FETCH_RD.
- BEQ: alu_src_a=1, alu_src_b=00, ALU_op=010, pc_write_cond=1, pc_source=01. Next state is FETCH_RD.
- JUMP: pc_write=1, pc_source=10. Next state is FETCH_RD.
- HALT: all enables are 0. exc_code holds its registered value (set on entry). The FSM stays in HALT until reset.
- exc_code is a register: cleared by reset, written only on the transition into HALT.
- Instruction latency in cycles, with W = FETCH_WAIT:
  - R-type and addi: 5 + W
  - beq and j: 4 + W

Test Plan:
- Reset held 3 cycles, then released: state_out=0 with all outputs 0 for one cycle, then 1. With FETCH_WAIT=1: states 1, 2, 3, 4; ir_write=1 exactly in state 3.
- opcode=0x00, funct=0x22, overflow=0: states 5 then 6. In state 5, alu_ctrl_sel=01. In state 6, reg_write=1 and reg_dst=1. Then back to 1; instruction takes 6 cycles.
- opcode=0x08, overflow=1 in ADDI_EXEC: state 11, exc_code=10, all enables 0 for the next 20 cycles. Reset then returns state_out=0 and exc_code=00.
- opcode=0x04, zero=1: BEQ state shows pc_write_cond=1, pc_source=01, ALU_op=010. Next state is 1.
- opcode=0x00, funct=0x08: DECODE -> HALT with exc_code=01. Separately, opcode=0x02: JUMP with pc_write=1, pc_source=10.
- FETCH_WAIT=0 and FETCH_WAIT=3 builds: FETCH_RD->FETCH_IR directly, and exactly 3 FETCH_WAIT_ST cycles, respectively. Reset asserted in FETCH_WAIT_ST -> RESET next edge and the counter is 0.
